cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Synthesizable run controller that drives the `rst_in`/`rdy_in` control inputs of `cpu` from the control side. It replaces hand-timed stimulus with a sequenced start, reset-hold, run and stop flow. It counts run cycles, stops on a CPU halt indication or a cycle budget, and can optionally inject pseudo-random `rdy` stalls. It sits between the top level (FPGA wrapper or bench) and `cpu`.

## Interface
Parameters:
- `RST_CYCLES`, 10: number of cycles `cpu_rst_out` is held high after start; must be ≥1.
- `RUN_CYCLES`, 50: cycle budget in RUN; 0 means no timeout.
- `STALL_SEED`, 16'hACE1: LFSR seed for stall injection; must be non-zero.

Ports:
- `clk_in`, in, 1: the single clock; all state changes on the rising edge.
- `rst_in`, in, 1: asynchronous, active-high reset.
- `start_in`, in, 1: start/restart request; sampled high on an edge.
- `halt_in`, in, 1: CPU halt indication (e.g. tohost write decode).
- `cpu_rst_out`, out, 1: drives `cpu.rst_in`.
- `cpu_rdy_out`, out, 1: drives `cpu.rdy_in`; 1 means the CPU advances.
- `busy_out`, out, 1: high in RESET or RUN.
- `done_out`, out, 1: high in DONE.
- `timeout_out`, out, 1: DONE was reached through the budget, not through a halt.
- `cycle_cnt_out`, out, 32: RUN cycles elapsed.
- `run_cnt_out`, out, 32: RUN cycles with `cpu_rdy_out`=1.

## Operation
- The FSM has four states: IDLE, RESET, RUN and DONE. All outputs are decoded from flops only; there is no combinational path from input to output.
- **Reset (`rst_in`=1, asynchronous):**
  - State goes to IDLE.
  - `cpu_rst_out`=1, `cpu_rdy_out`=0.
  - `busy_out`=`done_out`=`timeout_out`=0.
  - Both counters are 0.
  - The LFSR is loaded with `STALL_SEED`.
  - This applies in any state, including mid-RUN.
- **IDLE:**
  - Outputs: `cpu_rst_out`=1, `cpu_rdy_out`=0.
  - `start_in` moves to RESET. At the same time it clears both counters and `timeout_out`, reloads the LFSR and loads the hold counter with `RST_CYCLES`.
- **RESET:**
  - Outputs: `cpu_rst_out`=1, `cpu_rdy_out`=0.
  - The hold counter decrements every cycle; on reaching 0 the FSM moves to RUN.
  - `start_in` is ignored.
- **RUN:**
  - Outputs: `cpu_rst_out`=0; `cpu_rdy_out`=1, or per the LFSR when stall injection is enabled.
  - Every cycle, `cycle_cnt_out` increments by 1.
  - `run_cnt_out` increments by 1 in cycles where `cpu_rdy_out`=1.
  - Both counters saturate at 32'hFFFF_FFFF; they do not wrap.
  - Exit conditions:
    - `halt_in`=1 → DONE with `timeout_out`=0.
    - Otherwise, if `RUN_CYCLES`≠0 and `cycle_cnt_out`+1 == `RUN_CYCLES` → DONE with `timeout_out`=1.
    - If halt and budget expiry fall in the same cycle, halt wins and `timeout_out`=0.
  - `start_in` is ignored.
  - `halt_in` is honoured even in a stalled cycle.
- **DONE:**
  - Outputs: `cpu_rst_out`=0, `cpu_rdy_out`=0, so the CPU is frozen with its state intact.
  - Counters hold their values.
  - `start_in` restarts through the same actions as from IDLE.
  - `halt_in` is ignored.
- `halt_in` is ignored outside RUN.

## Timing
- Suppose `start_in` is sampled at edge k:
  - RESET occupies the cycles following edges k+1 … k+`RST_CYCLES`.
  - After edge k+`RST_CYCLES`+1, `cpu_rst_out`=0 and `cpu_rdy_out` is valid; this is the first RUN cycle.
- `halt_in` sampled in the n-th RUN cycle:
  - On the next edge, `done_out`=1 and `cpu_rdy_out`=0.
  - `cycle_cnt_out` reads n, which includes the halting cycle.
- Timeout: after exactly `RUN_CYCLES` RUN cycles, `done_out`=1 and `cycle_cnt_out`=`RUN_CYCLES`.
- Restart from DONE has the same latency as start from IDLE.

## Configuration
- `RUN_CTRL_STALL_INJECT_EN` **defined:**
  - A 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1 advances once per RUN cycle.
  - `cpu_rdy_out` = ~(lfsr[1:0]==2'b00), giving roughly 25% stall cycles.
  - The sequence is deterministic from `STALL_SEED`.
- **Not defined:**
  - No LFSR logic exists.
  - `cpu_rdy_out`=1 in every RUN cycle, so `run_cnt_out` == `cycle_cnt_out`.

## Structure
- Shared package holds:
  - the FSM state encoding (2 bits, IDLE=0, RESET=1, RUN=2, DONE=3);
  - the LFSR width and tap constants;
  - the counter width (32).
- Sub-module `run_ctrl_lfsr` contains the seed load, the enable-advance and the `stall` output. It is instantiated only under `RUN_CTRL_STALL_INJECT_EN`.

## Test plan
- Assert `rst_in` asynchronously in RUN cycle 7 → outputs switch immediately, without waiting for a clock edge, to `cpu_rst_out`=1, `cpu_rdy_out`=0, counters 0, `busy_out`=0. Release, then start → RESET runs the full `RST_CYCLES`.
- `RST_CYCLES`=4, `start_in` at edge 0 → `cpu_rst_out`=1 after edges 1–4 and 0 after edge 5; `busy_out`=1 from edge 1.
- `RUN_CYCLES`=0, `halt_in` in RUN cycle 20 → `done_out`=1, `timeout_out`=0, `cycle_cnt_out`=20, `cpu_rdy_out`=0. Then pulse `start_in` → counters clear and RESET restarts.
- `RUN_CYCLES`=50, no halt → DONE after 50 RUN cycles, `timeout_out`=1, `cycle_cnt_out`=50. Repeat with `halt_in` in cycle 50 → `timeout_out`=0.
- `start_in` and `halt_in` toggled during RESET and IDLE → no state change beyond the defined transitions.
- With `RUN_CTRL_STALL_INJECT_EN`, `RUN_CYCLES`=1000, two consecutive starts → `run_cnt_out` is identical for both runs, roughly 750, and strictly less than 1000. Without the macro, `run_cnt_out`=1000.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared constants for the CPU run controller: FSM encoding, LFSR shape, counter width.
// Stall injection is built only when RUN_CTRL_STALL_INJECT_EN is defined.
package cpu_run_ctrl_pkg;

    localparam int CNT_W  = 32;
    localparam int LFSR_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESET = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_lfsr.sv
// Seeded 16-bit Fibonacci LFSR that flags stall cycles for the run controller.
// Instantiated only when RUN_CTRL_STALL_INJECT_EN is defined.
module run_ctrl_lfsr
    import cpu_run_ctrl_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic load_in,
    input  logic adv_in,
    output logic stall_out
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_in) begin
            lfsr_d = SEED;
        end else if (adv_in) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_out = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the cpu: start -> reset hold -> run (budget/halt) -> done, with run counters.
// Optional pseudo-random rdy stalls are built when RUN_CTRL_STALL_INJECT_EN is defined.
//
// state | meaning
// IDLE  | after reset; cpu held in reset, waiting for start
// RESET | cpu reset held for RST_CYCLES cycles
// RUN   | cpu released, counters advance, waits for halt or budget
// DONE  | cpu frozen (rdy low), counters held, waiting for restart
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int                RST_CYCLES = 10,
    parameter int                RUN_CYCLES = 50,
    parameter logic [LFSR_W-1:0] STALL_SEED = 16'hACE1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             halt_in,
    output logic             cpu_rst_out,
    output logic             cpu_rdy_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             timeout_out,
    output logic [CNT_W-1:0] cycle_cnt_out,
    output logic [CNT_W-1:0] run_cnt_out
);

    localparam int               HOLD_W     = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] RUN_BUDGET = CNT_W'(RUN_CYCLES);
    localparam bit               HAS_BUDGET = (RUN_CYCLES != 0);

    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("RST_CYCLES must be at least 1");
    end
    if (STALL_SEED == '0) begin : g_bad_stall_seed
        $error("STALL_SEED must be non-zero");
    end

    logic [1:0]       state_q,     state_d;
    logic             start_q,     start_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] run_cnt_q,   run_cnt_d;
    logic             timeout_q,   timeout_d;
    logic             rdy_run;

`ifdef RUN_CTRL_STALL_INJECT_EN
    logic stall;
    logic lfsr_load;
    logic lfsr_adv;

    assign lfsr_load = start_q && (state_q == ST_IDLE || state_q == ST_DONE);
    assign lfsr_adv  = (state_q == ST_RUN);

    run_ctrl_lfsr #(
        .SEED (STALL_SEED)
    ) u_lfsr (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_in   (lfsr_load),
        .adv_in    (lfsr_adv),
        .stall_out (stall)
    );

    assign rdy_run = ~stall;
`else
    assign rdy_run = 1'b1;
`endif

    // Start is registered and only accepted when sampled in IDLE or DONE,
    // so a pulse landing on the last RUN/RESET edge cannot leak into a restart.
    always_comb begin
        start_d     = start_in && (state_q == ST_IDLE || state_q == ST_DONE);
        state_d     = state_q;
        hold_d      = hold_q;
        cycle_cnt_d = cycle_cnt_q;
        run_cnt_d   = run_cnt_q;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_q) begin
                    state_d     = ST_RESET;
                    hold_d      = HOLD_W'(RST_CYCLES);
                    cycle_cnt_d = '0;
                    run_cnt_d   = '0;
                    timeout_d   = 1'b0;
                end
            end
            ST_RESET: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
                if (rdy_run) begin
                    run_cnt_d = sat_inc(run_cnt_q);
                end
                // halt has priority over budget expiry in the same cycle
                if (halt_in) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b0;
                end else if (HAS_BUDGET && (cycle_cnt_q + CNT_W'(1)) == RUN_BUDGET) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            hold_q      <= '0;
            cycle_cnt_q <= '0;
            run_cnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            hold_q      <= hold_d;
            cycle_cnt_q <= cycle_cnt_d;
            run_cnt_q   <= run_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cpu_rst_out   = (state_q == ST_IDLE) || (state_q == ST_RESET);
    assign cpu_rdy_out   = (state_q == ST_RUN) && rdy_run;
    assign busy_out      = (state_q == ST_RESET) || (state_q == ST_RUN);
    assign done_out      = (state_q == ST_DONE);
    assign timeout_out   = timeout_q;
    assign cycle_cnt_out = cycle_cnt_q;
    assign run_cnt_out   = run_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed + randomized bench for cpu_run_ctrl; three instances cover budget 50, no budget and budget 1000.
module tb_cpu_run_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int MODEL_N = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [3];
    logic        start_s [3];
    logic        halt_s  [3];
    logic        crst_o  [3];
    logic        rdy_o   [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        to_o    [3];
    logic [31:0] cyc_o   [3];
    logic [31:0] run_o   [3];

    int checks = 0;
    int errors = 0;
    bit model_rdy [1:MODEL_N];

    cpu_run_ctrl #(.RST_CYCLES(4), .RUN_CYCLES(50), .STALL_SEED(SEED)) u_dut0 (
        .clk_in(clk), .rst_in(rst_s[0]), .start_in(start_s[0]), .halt_in(halt_s[0]),
        .cpu_rst_out(crst_o[0]), .cpu_rdy_out(rdy_o[0]), .busy_out(busy_o[0]),
        .done_out(done_o[0]), .timeout_out(to_o[0]),
        .cycle_cnt_out(cyc_o[0]), .run_cnt_out(run_o[0]));

    cpu_run_ctrl #(.RST_CYCLES(3), .RUN_CYCLES(0), .STALL_SEED(SEED)) u_dut1 (
        .clk_in(clk), .rst_in(rst_s[1]), .start_in(start_s[1]), .halt_in(halt_s[1]),
        .cpu_rst_out(crst_o[1]), .cpu_rdy_out(rdy_o[1]), .busy_out(busy_o[1]),
        .done_out(done_o[1]), .timeout_out(to_o[1]),
        .cycle_cnt_out(cyc_o[1]), .run_cnt_out(run_o[1]));

    cpu_run_ctrl #(.RST_CYCLES(2), .RUN_CYCLES(1000), .STALL_SEED(SEED)) u_dut2 (
        .clk_in(clk), .rst_in(rst_s[2]), .start_in(start_s[2]), .halt_in(halt_s[2]),
        .cpu_rst_out(crst_o[2]), .cpu_rdy_out(rdy_o[2]), .busy_out(busy_o[2]),
        .done_out(done_o[2]), .timeout_out(to_o[2]),
        .cycle_cnt_out(cyc_o[2]), .run_cnt_out(run_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Readiness of each RUN cycle, derived straight from the polynomial and seed.
    task automatic build_model();
        int s;
        int fb;
        s = int'(SEED);
        for (int c = 1; c <= MODEL_N; c++) begin
`ifdef RUN_CTRL_STALL_INJECT_EN
            model_rdy[c] = ((s % 4) != 0);
`else
            model_rdy[c] = 1'b1;
`endif
            fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
            s  = ((s << 1) | fb) & 16'hFFFF;
        end
    endtask

    task automatic idle_checks(input int k, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            halt_s[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_busy", busy_o[k], 0);
            chk("idle_cpu_rst", crst_o[k], 1);
            chk("idle_rdy", rdy_o[k], 0);
        end
        halt_s[k] = 1'b0;
    endtask

    // One full start..done sequence; halt_at = 0 means no halt is raised.
    task automatic do_run(input int k, input int rst_cycles, input int budget,
                          input int halt_at, output int run_res);
        int rexp;
        int n;
        bit to_exp;
        rexp = 0;
        n = 0;
        to_exp = 1'b0;
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        chk("pre_busy", busy_o[k], 0);
        for (int i = 1; i <= rst_cycles; i++) begin
            @(negedge clk);
            chk("rst_cpu_rst", crst_o[k], 1);
            chk("rst_busy", busy_o[k], 1);
            chk("rst_rdy", rdy_o[k], 0);
            chk("rst_done", done_o[k], 0);
            if (i == 1) begin
                chk("clr_cycle", cyc_o[k], 0);
                chk("clr_run", run_o[k], 0);
                chk("clr_timeout", to_o[k], 0);
            end
            if (i < rst_cycles) begin
                start_s[k] = 1'($urandom_range(0, 1));
                halt_s[k]  = 1'($urandom_range(0, 1));
            end else begin
                start_s[k] = 1'b0;
                halt_s[k]  = 1'b0;
            end
        end
        for (int c = 1; c <= MODEL_N; c++) begin
            @(negedge clk);
            chk("run_cpu_rst", crst_o[k], 0);
            chk("run_busy", busy_o[k], 1);
            chk("run_rdy", rdy_o[k], 32'(model_rdy[c]));
            chk("run_cycle", cyc_o[k], 32'(c - 1));
            chk("run_count", run_o[k], 32'(rexp));
            rexp += int'(model_rdy[c]);
            halt_s[k]  = (c == halt_at);
            start_s[k] = 1'($urandom_range(0, 1));
            if (c == halt_at) begin
                n = c;
                to_exp = 1'b0;
                break;
            end
            if (budget != 0 && c == budget) begin
                n = c;
                to_exp = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start_s[k] = 1'b0;
        halt_s[k]  = 1'b0;
        chk("done_flag", done_o[k], 1);
        chk("done_busy", busy_o[k], 0);
        chk("done_rdy", rdy_o[k], 0);
        chk("done_cpu_rst", crst_o[k], 0);
        chk("done_timeout", to_o[k], 32'(to_exp));
        chk("done_cycle", cyc_o[k], 32'(n));
        chk("done_run", run_o[k], 32'(rexp));
        for (int i = 0; i < 3; i++) begin
            halt_s[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_done", done_o[k], 1);
            chk("hold_cycle", cyc_o[k], 32'(n));
            chk("hold_run", run_o[k], 32'(rexp));
            chk("hold_timeout", to_o[k], 32'(to_exp));
        end
        halt_s[k] = 1'b0;
        run_res = rexp;
    endtask

    initial begin
        int r1;
        int r2;
        int h;
        for (int k = 0; k < 3; k++) begin
            rst_s[k]   = 1'b1;
            start_s[k] = 1'b0;
            halt_s[k]  = 1'b0;
        end
        build_model();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_cpu_rst", crst_o[k], 1);
            chk("reset_rdy", rdy_o[k], 0);
            chk("reset_busy", busy_o[k], 0);
            chk("reset_done", done_o[k], 0);
            chk("reset_timeout", to_o[k], 0);
            chk("reset_cycle", cyc_o[k], 0);
            chk("reset_run", run_o[k], 0);
            rst_s[k] = 1'b0;
        end
        idle_checks(0, 5);

        // budget 50: plain timeout, halt on the budget cycle, early halt
        do_run(0, 4, 50, 0, r1);
        do_run(0, 4, 50, 50, r1);
        do_run(0, 4, 50, 17, r1);
        for (int i = 0; i < 4; i++) begin
            h = int'($urandom_range(1, 60));
            do_run(0, 4, 50, h, r1);
        end

        // asynchronous reset in RUN cycle 7
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4 + 7) @(negedge clk);
        chk("pre_areset_cycle", cyc_o[0], 6);
        #2 rst_s[0] = 1'b1;
        #1;
        chk("areset_cpu_rst", crst_o[0], 1);
        chk("areset_rdy", rdy_o[0], 0);
        chk("areset_busy", busy_o[0], 0);
        chk("areset_cycle", cyc_o[0], 0);
        chk("areset_run", run_o[0], 0);
        @(negedge clk);
        rst_s[0] = 1'b0;
        idle_checks(0, 2);
        do_run(0, 4, 50, 5, r1);

        // no budget: halt decides, timeout never set
        idle_checks(1, 3);
        do_run(1, 3, 0, 20, r1);
        do_run(1, 3, 0, 1, r1);
        for (int i = 0; i < 3; i++) begin
            h = int'($urandom_range(1, 300));
            do_run(1, 3, 0, h, r1);
        end

        // budget 1000: two back-to-back runs must match
        do_run(2, 2, 1000, 0, r1);
        do_run(2, 2, 1000, 0, r2);
        chk("repeat_run_cnt", run_o[2], 32'(r1));
        chk("repeat_equal", 32'(r1), 32'(r2));
`ifdef RUN_CTRL_STALL_INJECT_EN
        chk("stall_below_budget", 32'(r2 < 1000), 1);
        chk("stall_near_75pct", 32'(r2 > 650 && r2 < 850), 1);
`else
        chk("no_stall_full", run_o[2], 1000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
